// File: rtl/pipe_stage_bank.sv
// pipe_stage_bank: a bank of STAGES inter-stage pipeline registers.
// Each register has a WIDTH-bit payload and a valid bit.
// A stall request freezes every upstream register and bubbles its own register.
// A flush request kills a register.
// Three saturating counters record retired, stalled and flushed cycles.
module pipe_stage_bank #(
  parameter int unsigned STAGES      = 4,
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned BUBBLE_ZERO = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STAGES*WIDTH-1:0]   d_in,
  input  logic [STAGES-1:0]         v_in,
  input  logic [STAGES-1:0]         stall_req,
  input  logic [STAGES-1:0]         flush_req,
  input  logic                      cnt_clr,
  output logic [STAGES*WIDTH-1:0]   q_out,
  output logic [STAGES-1:0]         v_out,
  output logic [STAGES-1:0]         frozen,
  output logic                      empty,
  output logic [CNT_W-1:0]          retire_cnt,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  // Register state. A packed layout lets q_out be a direct view of the registers.
  logic [STAGES-1:0][WIDTH-1:0] q_reg;
  logic [STAGES-1:0]            v_reg;
  logic [STAGES-1:0][WIDTH-1:0] q_next;
  logic [STAGES-1:0]            v_next;
  logic [STAGES-1:0]            bubble;

  logic [CNT_W-1:0] retire_reg;
  logic [CNT_W-1:0] stall_reg;
  logic [CNT_W-1:0] flush_reg;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // The last register has nothing downstream, so it never holds.
  assign frozen[STAGES-1] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES - 1; gi++) begin : g_frozen
      // A register holds when any stage further downstream is stalling.
      assign frozen[gi] = |stall_req[STAGES-1:gi+1];
    end

    for (gi = 0; gi < STAGES; gi++) begin : g_next
      // Flush beats freeze.
      // A stage's own stall only bubbles the register when nothing downstream froze it.
      assign bubble[gi] = flush_req[gi] | (stall_req[gi] & ~frozen[gi]);

      // A bubble either zeroes the payload or keeps it, depending on BUBBLE_ZERO.
      assign q_next[gi] = bubble[gi] ? ((BUBBLE_ZERO != 0) ? '0 : q_reg[gi])
                        : frozen[gi] ? q_reg[gi]
                        : d_in[gi*WIDTH +: WIDTH];

      assign v_next[gi] = bubble[gi] ? 1'b0
                        : frozen[gi] ? v_reg[gi]
                        : v_in[gi];
    end
  endgenerate

  // All state updates: pipeline registers and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg      <= '0;
      v_reg      <= '0;
      retire_reg <= '0;
      stall_reg  <= '0;
      flush_reg  <= '0;
    end else begin
      q_reg <= q_next;
      v_reg <= v_next;
      if (cnt_clr) begin
        retire_reg <= '0;
        stall_reg  <= '0;
        flush_reg  <= '0;
      end else begin
        if (v_reg[STAGES-1]) retire_reg <= sat_inc(retire_reg);
        if (|stall_req)      stall_reg  <= sat_inc(stall_reg);
        if (|flush_req)      flush_reg  <= sat_inc(flush_reg);
      end
    end
  end

  assign q_out      = q_reg;
  assign v_out      = v_reg;
  assign empty      = ~|v_reg;
  assign retire_cnt = retire_reg;
  assign stall_cnt  = stall_reg;
  assign flush_cnt  = flush_reg;

endmodule

// File: tb/tb_pipe_stage_bank.sv
// Testbench for pipe_stage_bank.
// Two instances are driven in parallel: BUBBLE_ZERO=1 and BUBBLE_ZERO=0.
// A behavioural model pushes the expected state into a scoreboard queue.
// Each entry is popped and compared after the clock edge.
module tb_pipe_stage_bank;
  localparam int S = 4;
  localparam int W = 8;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [S*W-1:0] d_in;
  logic [S-1:0]   v_in, stall_req, flush_req;
  logic           cnt_clr;

  logic [S*W-1:0] qa, qb;
  logic [S-1:0]   va, vb, fa, fb;
  logic           ea, eb;
  logic [C-1:0]   ra, sa, fca, rb, sb, fcb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_bank #(.STAGES(S), .WIDTH(W), .BUBBLE_ZERO(1), .CNT_W(C)) dut_a (
    .clk(clk), .rst(rst), .d_in(d_in), .v_in(v_in), .stall_req(stall_req),
    .flush_req(flush_req), .cnt_clr(cnt_clr), .q_out(qa), .v_out(va),
    .frozen(fa), .empty(ea), .retire_cnt(ra), .stall_cnt(sa), .flush_cnt(fca));

  pipe_stage_bank #(.STAGES(S), .WIDTH(W), .BUBBLE_ZERO(0), .CNT_W(C)) dut_b (
    .clk(clk), .rst(rst), .d_in(d_in), .v_in(v_in), .stall_req(stall_req),
    .flush_req(flush_req), .cnt_clr(cnt_clr), .q_out(qb), .v_out(vb),
    .frozen(fb), .empty(eb), .retire_cnt(rb), .stall_cnt(sb), .flush_cnt(fcb));

  typedef struct {
    logic [S*W-1:0] q_a;
    logic [S*W-1:0] q_b;
    logic [S-1:0]   v;
    int             r;
    int             s;
    int             f;
  } exp_t;

  exp_t sb_q[$];

  // Model state. The valid bits are the same for both BUBBLE_ZERO variants.
  logic [W-1:0] ma_q[S];
  logic [W-1:0] mb_q[S];
  logic [S-1:0] m_v;
  int m_r, m_s, m_f;

  function automatic int sat(input int c);
    return (c == (1 << C) - 1) ? c : c + 1;
  endfunction

  function automatic logic [S*W-1:0] all_bytes(input logic [7:0] b);
    logic [S*W-1:0] r;
    for (int k = 0; k < S; k++) r[k*W +: W] = b;
    return r;
  endfunction

  // One clock cycle.
  // Drive the inputs, check frozen, advance the model and push the expected state.
  // After the edge, pop the expected state and compare it with both DUTs.
  task automatic step(input logic r, input logic [S*W-1:0] d, input logic [S-1:0] vi,
                      input logic [S-1:0] st, input logic [S-1:0] fl, input logic clr);
    logic [S-1:0] frz;
    exp_t e;
    exp_t g;
    rst = r;
    d_in = d;
    v_in = vi;
    stall_req = st;
    flush_req = fl;
    cnt_clr = clr;

    for (int k = 0; k < S; k++) begin
      frz[k] = 1'b0;
      for (int j = k + 1; j < S; j++) frz[k] = frz[k] | st[j];
    end
    #1;
    checks++;
    if (fa !== frz || fb !== frz) begin
      errors++;
      $display("FAIL frozen: got a=%b b=%b expected %b", fa, fb, frz);
    end

    if (r) begin
      for (int k = 0; k < S; k++) begin
        ma_q[k] = '0;
        mb_q[k] = '0;
      end
      m_v = '0;
      m_r = 0;
      m_s = 0;
      m_f = 0;
    end else begin
      if (clr) begin
        m_r = 0;
        m_s = 0;
        m_f = 0;
      end else begin
        if (m_v[S-1]) m_r = sat(m_r);
        if (|st)      m_s = sat(m_s);
        if (|fl)      m_f = sat(m_f);
      end
      for (int k = 0; k < S; k++) begin
        if (fl[k] || (!frz[k] && st[k])) begin
          m_v[k] = 1'b0;
          ma_q[k] = '0;
        end else if (!frz[k]) begin
          m_v[k] = vi[k];
          ma_q[k] = d[k*W +: W];
          mb_q[k] = d[k*W +: W];
        end
      end
    end

    for (int k = 0; k < S; k++) begin
      e.q_a[k*W +: W] = ma_q[k];
      e.q_b[k*W +: W] = mb_q[k];
    end
    e.v = m_v;
    e.r = m_r;
    e.s = m_s;
    e.f = m_f;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    checks++;
    if (qa !== g.q_a || va !== g.v) begin
      errors++;
      $display("FAIL regs_bz1: got q=%h v=%b expected q=%h v=%b", qa, va, g.q_a, g.v);
    end
    checks++;
    if (qb !== g.q_b || vb !== g.v) begin
      errors++;
      $display("FAIL regs_bz0: got q=%h v=%b expected q=%h v=%b", qb, vb, g.q_b, g.v);
    end
    checks++;
    if (ea !== (g.v == '0) || eb !== (g.v == '0)) begin
      errors++;
      $display("FAIL empty: got a=%b b=%b expected %b", ea, eb, (g.v == '0));
    end
    checks++;
    if (ra !== C'(g.r) || sa !== C'(g.s) || fca !== C'(g.f) ||
        rb !== C'(g.r) || sb !== C'(g.s) || fcb !== C'(g.f)) begin
      errors++;
      $display("FAIL counters: got r=%0d s=%0d f=%0d expected r=%0d s=%0d f=%0d",
               ra, sa, fca, g.r, g.s, g.f);
    end
    $display("cycle rst=%b st=%b fl=%b clr=%b -> q=%h v=%b r=%0d s=%0d f=%0d",
             r, st, fl, clr, qa, va, ra, sa, fca);
  endtask

  task automatic test_reset();
    step(1'b1, 32'hDEADBEEF, 4'b1111, 4'b0101, 4'b1010, 1'b0);
    step(1'b1, 32'h12345678, 4'b0110, 4'b0000, 4'b0000, 1'b1);
    checks++;
    if (qa !== '0 || va !== 4'b0000 || ea !== 1'b1 || ra !== '0 || sa !== '0 || fca !== '0) begin
      errors++;
      $display("FAIL reset: got q=%h v=%b empty=%b expected zeros, empty=1", qa, va, ea);
    end
  endtask

  task automatic test_load();
    step(1'b0, 32'h13121110, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if (qa !== 32'h13121110 || va !== 4'b1111 || ea !== 1'b0) begin
      errors++;
      $display("FAIL load: got q=%h v=%b empty=%b expected 13121110 1111 0", qa, va, ea);
    end
    step(1'b0, 32'h13121110, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    checks++;
    if (ra !== 4'd1) begin
      errors++;
      $display("FAIL retire_inc: got %0d expected 1", ra);
    end
  endtask

  task automatic test_stall();
    step(1'b0, all_bytes(8'hAA), 4'b1111, 4'b0010, 4'b0000, 1'b0);
    checks++;
    if (qa !== 32'hAAAA0010 || va !== 4'b1101 || sa !== 4'd1) begin
      errors++;
      $display("FAIL stall: got q=%h v=%b s=%0d expected AAAA0010 1101 1", qa, va, sa);
    end
  endtask

  task automatic test_flush_over_freeze();
    step(1'b0, all_bytes(8'h55), 4'b1111, 4'b0100, 4'b0011, 1'b0);
    checks++;
    if (qa !== 32'h55000000 || va !== 4'b1000 || sa !== 4'd2 || fca !== 4'd1) begin
      errors++;
      $display("FAIL flush_freeze: got q=%h v=%b s=%0d f=%0d expected 55000000 1000 2 1",
               qa, va, sa, fca);
    end
  endtask

  task automatic test_bubble_keep();
    step(1'b1, '0, '0, '0, '0, 1'b0);
    step(1'b0, 32'h13121110, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, all_bytes(8'hAA), 4'b1111, 4'b0010, 4'b0000, 1'b0);
    checks++;
    if (qb[15:8] !== 8'h11 || vb[1] !== 1'b0) begin
      errors++;
      $display("FAIL bubble_keep: got q1=%h v1=%b expected 11 0", qb[15:8], vb[1]);
    end
  endtask

  task automatic test_saturate_clear();
    step(1'b1, '0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0F0E0D0C, 4'b1111, '0, '0, 1'b0);
    checks++;
    if (ra !== 4'd15) begin
      errors++;
      $display("FAIL saturate: got %0d expected 15", ra);
    end
    step(1'b0, 32'h0F0E0D0C, 4'b1111, '0, '0, 1'b1);
    checks++;
    if (ra !== 4'd0) begin
      errors++;
      $display("FAIL clear: got %0d expected 0", ra);
    end
    step(1'b0, 32'h0F0E0D0C, 4'b1111, '0, '0, 1'b0);
    checks++;
    if (ra !== 4'd1) begin
      errors++;
      $display("FAIL after_clear: got %0d expected 1", ra);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 150; i++) begin
      step(($urandom_range(0, 40) == 0), $urandom(), 4'($urandom()),
           ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'b0000,
           ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0000,
           ($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    d_in = '0;
    v_in = '0;
    stall_req = '0;
    flush_req = '0;
    cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_load();
    test_stall();
    test_flush_over_freeze();
    test_bubble_keep();
    test_saturate_clear();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_bank.md
Name: pipe_stage_bank

Overview:
- Parametrised bank of STAGES inter-stage pipeline registers, each WIDTH bits wide plus a valid bit.
- Replaces the hand-written IF/ID, ID/EX, EX/MEM and MEM/WB register block and its ad hoc stall/flush priority chain.
- Per-stage stall requests automatically freeze all upstream registers and insert a bubble.
- Per-stage flush requests kill register contents.
- Saturating performance counters record retired, stalled and flushed cycles.

Parameters:
- STAGES, 4: number of pipeline registers. Register k holds the output of stage k logic.
- WIDTH, 64: payload bits per register.
- BUBBLE_ZERO, 1: 1 means a bubble or flush zeroes the payload; 0 means the payload is kept and only valid is cleared.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- d_in  in  STAGES*WIDTH  stage logic outputs; slice [k*WIDTH +: WIDTH] feeds register k.
- v_in  in  STAGES  valid of each stage logic output.
- stall_req  in  STAGES  bit k: stage k cannot complete this cycle (for example, load-use at decode).
- flush_req  in  STAGES  bit k: register k must load a bubble (for example, branch/ret kill).
- cnt_clr  in  1  synchronous clear of all counters.
- q_out  out  STAGES*WIDTH  register payloads.
- v_out  out  STAGES  register valid bits.
- frozen  out  STAGES  bit k = OR of stall_req[j] for j>k (combinational); register k holds this cycle.
- empty  out  1  high when v_out is all zero (combinational from registers).
- retire_cnt  out  CNT_W  cycles with v_out[STAGES-1]=1.
- stall_cnt  out  CNT_W  cycles with any stall_req bit set.
- flush_cnt  out  CNT_W  cycles with any flush_req bit set.

Behaviour:
- Reset (rst=1 at a rising edge): all q_out=0, all v_out=0, all counters=0. Reset overrides every other input. Reset mid-stall or mid-flush is simply reset.
- Per register k, per edge, priority high to low:
  1. rst → q=0, v=0.
  2. flush_req[k] → bubble. Flush wins over freeze.
  3. frozen[k] → hold q and v.
  4. stall_req[k] → bubble. Stage k's own result is not committed; the downstream stage sees a NOP.
  5. Otherwise → q=d_in slice, v=v_in[k].
- Bubble definition: v=0; q=0 if BUBBLE_ZERO=1, else q unchanged.
- frozen[STAGES-1] is always 0, so the last register never holds.
- Latency: 1 cycle from d_in/v_in to q_out/v_out. No combinational path from d_in to q_out.
- v_in=0 with no stall or flush loads the payload with valid low; this is not counted as a bubble.
- Counters:
  - Each increments by 1 on an edge where its condition held in the preceding cycle.
  - Each saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 → counter=0 at the edge, overriding a simultaneous increment.
  - rst also clears all counters.
- Simultaneous stall_req on several stages: the most-downstream request dominates upstream freezing. Each requesting stage still bubbles its own register unless it is frozen by a further-downstream request.
- All state is in one clocked process. No latches, no asynchronous paths.

Test Plan:
(STAGES=4, WIDTH=8, CNT_W=4, BUBBLE_ZERO=1 unless stated.)
1. Assert rst for 2 cycles with arbitrary inputs → q_out=0, v_out=0000, all counters 0, empty=1.
2. v_in=1111, d_in slices {0x13,0x12,0x11,0x10} (stage 3..0), no stall/flush → after 1 edge q_out slice k=0x10+k, v_out=1111, empty=0; retire_cnt increments every following cycle.
3. From test 2 state, d_in all 0xAA, stall_req=0010 for 1 cycle → frozen=0001, reg0 holds 0x10, reg1=0x00 with v=0, regs 2 and 3=0xAA with v=1; stall_cnt=1.
4. flush_req=0011 and stall_req=0100 together, d_in all 0x55 → regs 0 and 1 flushed (v=0, q=0) despite freeze, reg2 bubble, reg3=0x55 v=1; stall_cnt and flush_cnt each +1.
5. BUBBLE_ZERO=0, register 1 holding 0x11, stall_req=0010 → reg1 q stays 0x11, v_out[1]=0.
6. v_in=1111 held for 20 cycles → retire_cnt saturates at 15. Then cnt_clr=1 with v_out[3]=1 → retire_cnt=0 next cycle, 1 the cycle after.
